// File: rtl/line_clear_ctrl.sv
// line_clear_ctrl
//   Owns the locked-board register that feeds the blit overlay base_state.
//   A lock request commits the overlay output (board plus active piece) into
//   the register, then the board is scanned bottom-up. Every full row is
//   collapsed and counted, and the spawn rows are checked for top-out.
//
//   Board layout (game_state_t): logic [9:0][19:0], indexed board[x][y],
//   x = column 0..9, y = row 0..19 (row 0 top, row 19 bottom).
//
//   Ports
//     clk, reset      system clock, synchronous active-high reset
//     lock_req        commit request, honoured only when idle
//     board_clear     new-game clear, honoured only when idle (wins over lock_req)
//     merged_state    blit overlay output (locked board plus active piece)
//     board_state     locked board register
//     busy            high while a lock sequence is in progress
//     lock_done       one-cycle pulse at the end of a lock sequence
//     lines_cleared   rows cleared by the last lock (saturates at 20)
//     total_lines     running cleared-row total (saturating)
//     game_over       sticky top-out flag
//     flash_active    high while a full row is flashed
//     flash_row       row being flashed/cleared
//
//   Build option: define LINE_CLEAR_FLASH_EN to hold each full row for
//   FLASH_CYCLES cycles with flash_active set before it collapses.
module line_clear_ctrl #(
    parameter int unsigned SPAWN_ROWS   = 2,
    parameter int unsigned FLASH_CYCLES = 8,
    parameter int unsigned COUNT_W      = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   lock_req,
    input  logic                   board_clear,
    input  logic [9:0][19:0]       merged_state,
    output logic [9:0][19:0]       board_state,
    output logic                   busy,
    output logic                   lock_done,
    output logic [4:0]             lines_cleared,
    output logic [COUNT_W-1:0]     total_lines,
    output logic                   game_over,
    output logic                   flash_active,
    output logic [4:0]             flash_row
);

    localparam logic [4:0] LAST_ROW  = 5'd19;
    localparam logic [4:0] MAX_LINES = 5'd20;

    typedef enum logic [2:0] {
        S_IDLE,
        S_COMMIT,
        S_SCAN,
`ifdef LINE_CLEAR_FLASH_EN
        S_FLASH,
`endif
        S_COLLAPSE,
        S_DONE
    } state_t;

    state_t               state_q;
    logic [9:0][19:0]     board_q;
    logic [4:0]           ptr_q;
    logic                 busy_q;
    logic                 done_q;
    logic [4:0]           lines_q;
    logic [COUNT_W-1:0]   total_q;
    logic                 over_q;
    logic [4:0]           frow_q;

`ifdef LINE_CLEAR_FLASH_EN
    localparam int unsigned FW = (FLASH_CYCLES > 1) ? $clog2(FLASH_CYCLES) : 1;
    logic          flash_q;
    logic [FW-1:0] fcnt_q;
`endif

    logic             row_full_d;
    logic             above_full_d;
    logic [4:0]       above_idx_d;
    logic [9:0][19:0] collapsed_d;
    logic             topout_d;

    always_comb begin
        row_full_d   = 1'b1;
        above_idx_d  = (ptr_q == '0) ? '0 : ptr_q - 5'd1;
        above_full_d = (ptr_q != '0);
        for (int unsigned x = 0; x < 10; x++) begin
            row_full_d   = row_full_d & board_q[x][ptr_q];
            above_full_d = above_full_d & board_q[x][above_idx_d];
        end

        // Remove row ptr: everything above it drops by one, row 0 refills empty.
        collapsed_d = board_q;
        for (int unsigned x = 0; x < 10; x++) begin
            collapsed_d[x][0] = 1'b0;
            for (int unsigned y = 1; y < 20; y++) begin
                if (5'(y) <= ptr_q) begin
                    collapsed_d[x][y] = board_q[x][y-1];
                end
            end
        end

        topout_d = 1'b0;
        for (int unsigned y = 0; y < SPAWN_ROWS && y < 20; y++) begin
            for (int unsigned x = 0; x < 10; x++) begin
                topout_d = topout_d | board_q[x][y];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            board_q <= '0;
            ptr_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            lines_q <= '0;
            total_q <= '0;
            over_q  <= 1'b0;
            frow_q  <= '0;
`ifdef LINE_CLEAR_FLASH_EN
            flash_q <= 1'b0;
            fcnt_q  <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (board_clear) begin
                        board_q <= '0;
                        total_q <= '0;
                        over_q  <= 1'b0;
                        lines_q <= '0;
                    end else if (lock_req) begin
                        lines_q <= '0;
                        busy_q  <= 1'b1;
                        state_q <= S_COMMIT;
                    end
                end
                S_COMMIT: begin
                    board_q <= merged_state;
                    ptr_q   <= LAST_ROW;
                    state_q <= S_SCAN;
                end
                S_SCAN: begin
                    if (row_full_d) begin
                        frow_q <= ptr_q;
`ifdef LINE_CLEAR_FLASH_EN
                        flash_q <= 1'b1;
                        fcnt_q  <= FW'(FLASH_CYCLES - 1);
                        state_q <= S_FLASH;
`else
                        state_q <= S_COLLAPSE;
`endif
                    end else if (ptr_q == '0) begin
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        ptr_q <= ptr_q - 5'd1;
                    end
                end
`ifdef LINE_CLEAR_FLASH_EN
                S_FLASH: begin
                    if (fcnt_q == '0) begin
                        flash_q <= 1'b0;
                        state_q <= S_COLLAPSE;
                    end else begin
                        fcnt_q <= fcnt_q - FW'(1);
                    end
                end
`endif
                S_COLLAPSE: begin
                    board_q <= collapsed_d;
                    if (lines_q != MAX_LINES) lines_q <= lines_q + 5'd1;
                    if (total_q != '1) total_q <= total_q + COUNT_W'(1);
                    // The re-check of row ptr is folded into this cycle: after the
                    // collapse it holds the old row ptr-1, so its fullness is known
                    // now and no separate scan cycle is spent on it.
                    if (above_full_d) begin
`ifdef LINE_CLEAR_FLASH_EN
                        flash_q <= 1'b1;
                        fcnt_q  <= FW'(FLASH_CYCLES - 1);
                        state_q <= S_FLASH;
`else
                        state_q <= S_COLLAPSE;
`endif
                    end else if (ptr_q == '0) begin
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        ptr_q   <= ptr_q - 5'd1;
                        state_q <= S_SCAN;
                    end
                end
                S_DONE: begin
                    over_q  <= over_q | topout_d;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign board_state   = board_q;
    assign busy          = busy_q;
    assign lock_done     = done_q;
    assign lines_cleared = lines_q;
    assign total_lines   = total_q;
    assign game_over     = over_q;
    assign flash_row     = frow_q;

`ifdef LINE_CLEAR_FLASH_EN
    assign flash_active = flash_q;
`else
    logic unused_flash_cycles;
    assign unused_flash_cycles = (FLASH_CYCLES != 0);
    assign flash_active        = 1'b0;
`endif

endmodule
